// File: rtl/circuit_sweep_pkg.sv
// Shared types and sizing helpers for the exhaustive circuit sweep sequencer.
// Used by the sweep controller and its signature register.
package circuit_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CAPTURE,
    FINISH
  } state_e;

  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'hFFFF;

  // One spare bit so the last-vector compare never aliases.
  function automatic int vec_cnt_w(input int n_in);
    return n_in + 1;
  endfunction

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int settle);
    return (settle > 0) ? $clog2(settle + 1) : 1;
  endfunction

endpackage

// File: rtl/sweep_misr.sv
// Multiple-input signature register compacting one output word per step.
// Shifts left with polynomial feedback from the MSB, then folds in din.
module sweep_misr
  import circuit_sweep_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (init) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = (sig_q << 1)
            ^ (sig_q[WIDTH-1] ? POLY : '0)
            ^ din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/circuit_sweep_ctrl.sv
// Drives every input vector into a combinational circuit, records its truth
// table and compacts the outputs into a MISR signature.
module circuit_sweep_ctrl
  import circuit_sweep_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int N_OUT = 16,
  parameter int SETTLE = 1,
  parameter logic [N_OUT-1:0] POLY = N_OUT'(DEF_POLY),
  parameter logic [N_OUT-1:0] SEED = N_OUT'(DEF_SEED)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  output logic [N_IN-1:0]             x,
  input  logic [N_OUT-1:0]            f,
  output logic                        busy,
  output logic                        done,
  output logic                        sig_valid,
  output logic [N_OUT-1:0]            signature,
  input  logic [sel_w(N_OUT)-1:0]     tt_sel,
  output logic [(1<<N_IN)-1:0]        tt_row
);

  localparam int V  = 1 << N_IN;
  localparam int VW = vec_cnt_w(N_IN);
  localparam int CW = cnt_w(SETTLE);
  localparam int SW = sel_w(N_OUT);

  state_e                     state_q, state_d;
  logic [VW-1:0]              vec_q, vec_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [N_IN-1:0]            x_q, x_d;
  logic                       done_q, done_d;
  logic                       valid_q, valid_d;
  logic [N_OUT-1:0][V-1:0]    tt_q, tt_d;
  logic                       misr_init;
  logic                       misr_en;
  logic [(1<<SW)-1:0][V-1:0]  tt_pad;

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    tt_d      = tt_q;
    misr_init = 1'b0;
    misr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = DRIVE;
          x_d       = '0;
          vec_d     = '0;
          valid_d   = 1'b0;
          tt_d      = '0;
          misr_init = 1'b1;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
          x_d     = '0;
        end else begin
          cnt_d   = CW'(SETTLE);
          state_d = (SETTLE == 0) ? CAPTURE : WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
          x_d     = '0;
        end else if (cnt_q == CW'(1)) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_d = IDLE;
          x_d     = '0;
        end else begin
          for (int j = 0; j < N_OUT; j++) begin
            tt_d[j][vec_q[N_IN-1:0]] = f[j];
          end
          misr_en = 1'b1;
          if (vec_q == VW'(V - 1)) begin
            state_d = FINISH;
          end else begin
            vec_d   = vec_q + VW'(1);
            x_d     = vec_d[N_IN-1:0];
            state_d = DRIVE;
          end
        end
      end
      FINISH: begin
        // Abort is deliberately not sampled here: the sweep is complete.
        state_d = IDLE;
        done_d  = 1'b1;
        valid_d = 1'b1;
        x_d     = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      tt_q    <= tt_d;
    end
  end

  sweep_misr #(
    .WIDTH (N_OUT),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk   (clk),
    .rst   (rst),
    .init  (misr_init),
    .en    (misr_en),
    .din   (f),
    .sig   (signature)
  );

  // Rows beyond N_OUT read back as zero.
  always_comb begin
    tt_pad            = '0;
    tt_pad[N_OUT-1:0] = tt_q;
  end

  assign tt_row    = tt_pad[tt_sel];
  assign x         = x_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign sig_valid = valid_q;

endmodule
